booth_product_accumulator: RTL and testbench

- Downstream stage of the sequential 4x4 Booth multiplier. Each 8-bit signed product the multiplier produces is accepted by this block over a valid/ready handshake.
- The block sign-extends each product and accumulates N_TERMS of them into a wider signed sum, forming a dot product.
- It presents the finished sum on an output valid/ready handshake, with optional saturation and a sticky overflow flag.

---
 rtl/booth_product_accumulator_pkg.sv | 59 +++++
 rtl/booth_sat_adder.sv | 30 +++
 rtl/booth_product_accumulator.sv | 120 ++++++++++++
 tb/tb_booth_product_accumulator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_product_accumulator_pkg.sv
// Shared types and arithmetic helpers for the Booth product accumulator.
// Contents:
//   state_t          two-state accumulate / hold-result FSM encoding
//   acc_max/acc_min  signed limits of a w-bit accumulator (ACC_MAX / ACC_MIN)
//   sat_add          w-bit signed add with overflow flag and optional clamp
// Operands and results travel in CALC_W-bit signed containers, so one helper
// serves every accumulator width from 1 to CALC_W-1 bits.
package booth_product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned CALC_W  = 32;
    localparam int unsigned CALC_IW = $clog2(CALC_W);

    typedef struct packed {
        logic signed [CALC_W-1:0] sum;
        logic                     ovf;
    } sat_sum_t;

    // Largest signed value of a w-bit accumulator: 2^(w-1) - 1.
    function automatic logic signed [CALC_W-1:0] acc_max(input int unsigned w);
        logic signed [CALC_W-1:0] one;
        one = CALC_W'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    // Smallest signed value of a w-bit accumulator: -2^(w-1).
    function automatic logic signed [CALC_W-1:0] acc_min(input int unsigned w);
        logic signed [CALC_W-1:0] one;
        one = CALC_W'(1);
        return -(one <<< (w - 1));
    endfunction

    // a and b must already lie in the w-bit signed range.
    function automatic sat_sum_t sat_add(input logic signed [CALC_W-1:0] a,
                                         input logic signed [CALC_W-1:0] b,
                                         input int unsigned              w,
                                         input logic                     saturate);
        sat_sum_t                 res;
        logic signed [CALC_W-1:0] raw;
        logic [CALC_IW-1:0]       msb;
        msb = CALC_IW'(w - 1);
        raw = a + b;
        // Keep the low w bits, sign-extended: the modulo-2^w result.
        raw = (raw <<< (CALC_W - w)) >>> (CALC_W - w);
        // Like-signed operands whose result flips sign have overflowed.
        res.ovf = (a[msb] == b[msb]) && (raw[msb] != a[msb]);
        if (res.ovf && saturate) begin
            res.sum = a[msb] ? acc_min(w) : acc_max(w);
        end else begin
            res.sum = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/booth_sat_adder.sv
// Combinational ACC_W-bit signed adder with overflow detect and optional clamp.
// Ports:
//   a, b   in   ACC_W  signed operands
//   sum_c  out  ACC_W  wrapped or clamped sum (clamped when SATURATE != 0)
//   ovf_c  out  1      signed overflow occurred in this addition
module booth_sat_adder
    import booth_product_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned SATURATE = 1
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum_c,
    output logic                    ovf_c
);

    sat_sum_t res;
    logic     unused_sum_hi;

    always_comb begin
        res = sat_add(CALC_W'(a), CALC_W'(b), ACC_W, SATURATE != 0);
    end

    assign sum_c         = ACC_W'(res.sum);
    assign ovf_c         = res.ovf;
    // Upper container bits only replicate the sign of the w-bit result.
    assign unused_sum_hi = ^res.sum[CALC_W-1:ACC_W];

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates N_TERMS signed Booth products into one wide signed dot product.
// Requires PROD_W <= ACC_W <= 31 and N_TERMS >= 1.
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   clear                    synchronous flush of partial group and pending result
//   prod_valid/ready/data    product input handshake (PROD_W signed)
//   sum_valid/ready/data     result output handshake (ACC_W signed)
//   sum_ovf                  at least one overflow while forming this result
//   term_count               products accepted so far in the current group
module booth_product_accumulator
    import booth_product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W   = 8,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned N_TERMS  = 4,
    parameter int unsigned SATURATE = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           prod_valid,
    output logic                           prod_ready,
    input  logic [PROD_W-1:0]              prod_data,
    output logic                           sum_valid,
    input  logic                           sum_ready,
    output logic [ACC_W-1:0]               sum_data,
    output logic                           sum_ovf,
    output logic [$clog2(N_TERMS+1)-1:0]   term_count
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic                    last_term;
    logic                    sticky;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] add_sum;

    assign prod_ext  = ACC_W'($signed(prod_data));
    assign last_term = (term_count == CNT_W'(N_TERMS - 1));

    booth_sat_adder #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_adder (
        .a     (acc),
        .b     (prod_ext),
        .sum_c (add_sum),
        .ovf_c (add_ovf)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear overrides; HOLD exits on the result handoff.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && last_term) state_next = HOLD;
                HOLD:    if (sum_ready)           state_next = ACCUM;
                default:                          state_next = ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        prod_ready = 1'b0;
        sum_valid  = 1'b0;
        if (state == ACCUM) begin
            prod_ready = !clear;
        end else begin
            sum_valid  = 1'b1;
        end
        accept = prod_valid && prod_ready;
    end

    // Accumulator, group counter, sticky flag and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            term_count <= '0;
            sticky     <= 1'b0;
            sum_data   <= '0;
            sum_ovf    <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            term_count <= '0;
            sticky     <= 1'b0;
            sum_data   <= '0;
            sum_ovf    <= 1'b0;
        end else if (accept) begin
            if (last_term) begin
                sum_data   <= add_sum;
                sum_ovf    <= sticky | add_ovf;
                acc        <= '0;
                term_count <= '0;
                sticky     <= 1'b0;
            end else begin
                acc        <= add_sum;
                term_count <= term_count + CNT_W'(1);
                sticky     <= sticky | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: three configurations share one stimulus
// stream (16-bit/4 terms saturating, 8-bit/2 terms saturating, 8-bit/2 terms
// wrapping). A behavioural model per instance predicts every output cycle.
module tb_booth_product_accumulator;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       prod_valid;
    logic [7:0] prod_data;
    logic       sum_ready;

    logic        prod_ready_d, sum_valid_d, sum_ovf_d;
    logic [15:0] sum_data_d;
    logic [2:0]  term_count_d;
    logic        prod_ready_s, sum_valid_s, sum_ovf_s;
    logic [7:0]  sum_data_s;
    logic [1:0]  term_count_s;
    logic        prod_ready_w, sum_valid_w, sum_ovf_w;
    logic [7:0]  sum_data_w;
    logic [1:0]  term_count_w;

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(4), .SATURATE(1)) dut_d (
        .clk(clk), .reset(reset), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready_d), .prod_data(prod_data),
        .sum_valid(sum_valid_d), .sum_ready(sum_ready), .sum_data(sum_data_d),
        .sum_ovf(sum_ovf_d), .term_count(term_count_d)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(2), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready_s), .prod_data(prod_data),
        .sum_valid(sum_valid_s), .sum_ready(sum_ready), .sum_data(sum_data_s),
        .sum_ovf(sum_ovf_s), .term_count(term_count_s)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(2), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready_w), .prod_data(prod_data),
        .sum_valid(sum_valid_w), .sum_ready(sum_ready), .sum_data(sum_data_w),
        .sum_ovf(sum_ovf_w), .term_count(term_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int groups  = 0;

    // Per-instance configuration and model state.
    int     acc_w_of[3] = '{16, 8, 8};
    int     n_of[3]     = '{4, 2, 2};
    bit     sat_of[3]   = '{1'b1, 1'b1, 1'b0};
    longint m_acc[3];
    longint m_cnt[3];
    longint m_sum[3];
    bit     m_sticky[3];
    bit     m_hold[3];
    bit     m_ovf[3];

    logic signed [63:0] o_pr[3];
    logic signed [63:0] o_sv[3];
    logic signed [63:0] o_sd[3];
    logic signed [63:0] o_so[3];
    logic signed [63:0] o_tc[3];

    task automatic check(input string name, input logic signed [63:0] got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Plain integer w-bit signed add with clamp or modulo wrap.
    function automatic void madd(input longint a, input longint p, input int w, input bit sat,
                                 output longint s, output bit o);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        s  = a + p;
        o  = 1'b0;
        if (s > hi) begin
            o = 1'b1;
            s = sat ? hi : s - (longint'(1) << w);
        end else if (s < lo) begin
            o = 1'b1;
            s = sat ? lo : s + (longint'(1) << w);
        end
    endfunction

    // One clock cycle: compare all instances on the falling edge, advance the
    // models for the coming rising edge, then return 1 time unit past it.
    task automatic step();
        longint s;
        bit     o;
        @(negedge clk);
        o_pr[0] = 64'(prod_ready_d); o_sv[0] = 64'(sum_valid_d); o_so[0] = 64'(sum_ovf_d);
        o_sd[0] = 64'($signed(sum_data_d)); o_tc[0] = 64'(term_count_d);
        o_pr[1] = 64'(prod_ready_s); o_sv[1] = 64'(sum_valid_s); o_so[1] = 64'(sum_ovf_s);
        o_sd[1] = 64'($signed(sum_data_s)); o_tc[1] = 64'(term_count_s);
        o_pr[2] = 64'(prod_ready_w); o_sv[2] = 64'(sum_valid_w); o_so[2] = 64'(sum_ovf_w);
        o_sd[2] = 64'($signed(sum_data_w)); o_tc[2] = 64'(term_count_w);
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                check($sformatf("rst_valid%0d", i), o_sv[i], 0);
                check($sformatf("rst_data%0d", i),  o_sd[i], 0);
                check($sformatf("rst_count%0d", i), o_tc[i], 0);
                m_acc[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
                m_sticky[i] = 1'b0; m_hold[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
                check($sformatf("ready%0d", i), o_pr[i], longint'(!m_hold[i] && !clear));
                check($sformatf("valid%0d", i), o_sv[i], longint'(m_hold[i]));
                if (m_hold[i]) begin
                    check($sformatf("data%0d", i), o_sd[i], m_sum[i]);
                    check($sformatf("ovf%0d", i),  o_so[i], longint'(m_ovf[i]));
                end
                check($sformatf("count%0d", i), o_tc[i], m_cnt[i]);
                if (clear) begin
                    m_acc[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0; m_hold[i] = 1'b0;
                end else if (m_hold[i]) begin
                    if (sum_ready) begin
                        m_hold[i] = 1'b0;
                        if (i == 0) groups++;
                    end
                end else if (prod_valid) begin
                    madd(m_acc[i], longint'($signed(prod_data)), acc_w_of[i], sat_of[i], s, o);
                    if (m_cnt[i] + 1 == longint'(n_of[i])) begin
                        m_sum[i] = s; m_ovf[i] = m_sticky[i] | o; m_hold[i] = 1'b1;
                        m_acc[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0;
                    end else begin
                        m_acc[i] = s; m_cnt[i]++; m_sticky[i] = m_sticky[i] | o;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        prod_valid = 1'b1;
        prod_data  = 8'(d);
        step();
    endtask

    task automatic release_result();
        prod_valid = 1'b0;
        sum_ready  = 1'b1;
        step();
        sum_ready  = 1'b0;
    endtask

    initial begin
        int cyc;
        int mode;
        reset = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod_data = '0; sum_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("ready_after_reset", 64'(prod_ready_d), 1);

        // Basic dot product, one cycle after the last accept.
        send(21); send(-8); send(35); send(64);
        prod_valid = 1'b0;
        check("dot_valid", 64'(sum_valid_d), 1);
        check("dot_112",   64'($signed(sum_data_d)), 112);
        check("dot_ovf",   64'(sum_ovf_d), 0);
        check("dot_count", 64'(term_count_d), 0);

        // Backpressure: result held, products refused.
        prod_valid = 1'b1;
        prod_data  = 8'd99;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_ready", 64'(prod_ready_d), 0);
            check("bp_hold",  64'($signed(sum_data_d)), 112);
        end
        release_result();
        check("handoff_valid", 64'(sum_valid_d), 0);
        check("handoff_ready", 64'(prod_ready_d), 1);

        // Overflow on the 8-bit instances.
        send(64); send(64);
        prod_valid = 1'b0;
        check("sat_127",   64'($signed(sum_data_s)), 127);
        check("sat_ovf",   64'(sum_ovf_s), 1);
        check("wrap_m128", 64'($signed(sum_data_w)), -128);
        check("wrap_ovf",  64'(sum_ovf_w), 1);
        release_result();
        send(1); send(2);
        prod_valid = 1'b0;
        check("after_ovf_3",   64'($signed(sum_data_s)), 3);
        check("after_ovf_clr", 64'(sum_ovf_s), 0);
        check("wide_131",      64'($signed(sum_data_d)), 131);
        release_result();

        // Clear mid-group discards the partial sum and the coincident product.
        send(10); send(20);
        clear      = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 8'd5;
        #1;
        check("clear_ready", 64'(prod_ready_d), 0);
        step();
        clear      = 1'b0;
        prod_valid = 1'b0;
        check("clear_count", 64'(term_count_d), 0);
        send(1); send(2); send(3); send(4);
        prod_valid = 1'b0;
        check("after_clear_10", 64'($signed(sum_data_d)), 10);
        release_result();

        // Asynchronous reset while a result is held.
        send(21); send(-8); send(35); send(64);
        prod_valid = 1'b0;
        check("pre_reset_valid", 64'(sum_valid_d), 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_valid", 64'(sum_valid_d), 0);
        check("async_data",  64'(sum_data_d), 0);
        step();
        reset = 1'b0;
        check("post_reset_ready", 64'(prod_ready_d), 1);
        send(5); send(6); send(7); send(8);
        prod_valid = 1'b0;
        check("fresh_26", 64'($signed(sum_data_d)), 26);
        release_result();

        // Randomised handshakes on both ports with occasional clears.
        groups = 0;
        cyc    = 0;
        while (groups < 1000 && cyc < 40000) begin
            mode       = (cyc / 300) % 3;
            prod_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : 1'(($urandom % 4) == 0);
            sum_ready  = (mode == 2) ? 1'b1 : (mode == 0) ? 1'($urandom % 2) : 1'(($urandom % 3) == 0);
            prod_data  = 8'($urandom);
            clear      = 1'(($urandom % 150) == 0);
            step();
            cyc++;
        end
        clear = 1'b0;
        check("random_groups_done", 64'(groups >= 1000), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
